// File: rtl/my_skid_reg.sv
// my_skid_reg: two-entry valid/ready skid buffer.
//
// Sits downstream of a plain enable/reset data register and turns its output
// into a fully handshaken stage. The second (skid) entry absorbs the beat
// that arrives in the same cycle the downstream stalls. Because of that,
// in_ready_o only depends on registered state plus the rst/flush/enable
// controls, and never on out_ready_i. This breaks long ready chains while
// still sustaining one beat per cycle.
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   rst_i        synchronous active-high reset
//   en_i         stage enable; low freezes state and blocks both handshakes
//   flush_i      synchronous flush; drops buffered beats, keeps data values
//   in_valid_i   upstream beat valid
//   in_ready_o   stage can accept a beat this cycle
//   in_data_i    upstream data
//   out_valid_o  main entry holds a beat
//   out_ready_i  downstream accepts
//   out_data_o   main entry data
//   level_o      occupancy (0, 1 or 2)
module my_skid_reg #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        level_o
);

    // Occupancy decoded from {main_v, skid_v}; 01 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_d, skid_d;

    logic              main_v_nxt, skid_v_nxt;
    logic [DATA_W-1:0] main_d_nxt, skid_d_nxt;

    logic   in_fire, out_fire;
    state_t state;

    assign state = state_t'({main_v, skid_v});

    // Ready is taken from skid_v (registered) rather than from out_ready_i.
    assign in_ready_o  = en_i & ~rst_i & ~flush_i & ~skid_v;
    assign out_valid_o = main_v & en_i & ~flush_i;
    assign out_data_o  = main_d;
    assign level_o     = {1'b0, main_v} + {1'b0, skid_v};

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        main_v_nxt = main_v;
        skid_v_nxt = skid_v;
        main_d_nxt = main_d;
        skid_d_nxt = skid_d;

        if (flush_i) begin
            // Only the valids are dropped; stale data is harmless.
            main_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
        end else if (en_i) begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_v_nxt = 1'b1;
                        main_d_nxt = in_data_i;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d_nxt = in_data_i;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_v_nxt = 1'b1;
                        skid_d_nxt = in_data_i;
                    end else if (out_fire) begin
                        main_v_nxt = 1'b0;
                    end
                end
                FULL: begin
                    // in_ready_o is low here, so only the drain side moves.
                    if (out_fire) begin
                        main_d_nxt = skid_d;
                        skid_v_nxt = 1'b0;
                    end
                end
                default: begin
                    // Unreachable skid-only state; fall back to empty.
                    main_v_nxt = 1'b0;
                    skid_v_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RST_VAL;
            skid_d <= RST_VAL;
        end else begin
            main_v <= main_v_nxt;
            skid_v <= skid_v_nxt;
            main_d <= main_d_nxt;
            skid_d <= skid_d_nxt;
        end
    end

endmodule
